// File: rtl/cafeteira_sequenciador_pkg.sv
// Shared types for the brew sequencer: FSM state encoding, error causes and a
// constant helper used to size the shared timer.
package cafeteira_sequenciador_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_PREPARA       = 4'd1,
        ST_ESPERA_MODO   = 4'd2,
        ST_MEDE_AGUA     = 4'd3,
        ST_ESPERA_AGUA   = 4'd4,
        ST_MEDE_XICARA   = 4'd5,
        ST_ESPERA_XICARA = 4'd6,
        ST_PROX_ETAPA    = 4'd7,
        ST_EXEC_ETAPA    = 4'd8,
        ST_ERRO          = 4'd9,
        ST_FIM           = 4'd10
    } estado_t;

    typedef enum logic [2:0] {
        ERR_NENHUM         = 3'd0,
        ERR_SEM_AGUA       = 3'd1,
        ERR_SEM_XICARA     = 3'd2,
        ERR_TIMEOUT_AGUA   = 3'd3,
        ERR_TIMEOUT_XICARA = 3'd4,
        ERR_TIMEOUT_ETAPA  = 3'd5,
        ERR_CANCELADO      = 3'd6,
        ERR_RECEITA_VAZIA  = 3'd7
    } erro_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cafeteira_sequenciador_if.sv
// Control/status bundle between the recipe front end, the sensors, the
// actuator drivers and the brew sequencer.
interface cafeteira_sequenciador_if #(
    parameter int NUM_ETAPAS = 3
);
    logic                  preparar;
    logic                  cancelar;
    logic                  pronto_serial;
    logic [NUM_ETAPAS-1:0] mascara_etapas;
    logic                  pronto_sensor_agua;
    logic                  suficiente;
    logic                  pronto_sensor_xicara;
    logic                  tem_xicara;
    logic [NUM_ETAPAS-1:0] fim_etapa;
    logic                  zera_sensores;
    logic                  medir_agua;
    logic                  verifica_xicara;
    logic [NUM_ETAPAS-1:0] liga_etapa;
    logic [2:0]            etapa_atual;
    logic                  ocupado;
    logic                  concluido;
    logic                  erro;
    logic [2:0]            erro_codigo;
    logic [3:0]            db_estado;

    modport master (
        output preparar, cancelar, pronto_serial, mascara_etapas,
               pronto_sensor_agua, suficiente, pronto_sensor_xicara, tem_xicara, fim_etapa,
        input  zera_sensores, medir_agua, verifica_xicara, liga_etapa, etapa_atual,
               ocupado, concluido, erro, erro_codigo, db_estado
    );

    modport slave (
        input  preparar, cancelar, pronto_serial, mascara_etapas,
               pronto_sensor_agua, suficiente, pronto_sensor_xicara, tem_xicara, fim_etapa,
        output zera_sensores, medir_agua, verifica_xicara, liga_etapa, etapa_atual,
               ocupado, concluido, erro, erro_codigo, db_estado
    );
endinterface

// File: rtl/cafeteira_sequenciador_temporizador.sv
// Saturating cycle counter shared by all wait states; fim_o flags the last
// cycle (count == limit-1) of a wait that started from a clear.
module cafeteira_sequenciador_temporizador #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa_i,
    input  logic         habilita_i,
    input  logic [W-1:0] limite_i,
    output logic         fim_o
);
    localparam logic [W-1:0] UM       = W'(1);
    localparam logic [W-1:0] SATURADO = '1;

    logic [W-1:0] conta_q, conta_d;

    always_comb begin
        conta_d = conta_q;
        if (limpa_i) begin
            conta_d = '0;
        end else if (habilita_i && (conta_q != SATURADO)) begin
            conta_d = conta_q + UM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            conta_q <= '0;
        end else begin
            conta_q <= conta_d;
        end
    end

    assign fim_o = habilita_i && (conta_q == (limite_i - UM));

endmodule

// File: rtl/cafeteira_sequenciador.sv
// Brew sequencer: checks water and cup with bounded retries, then runs the
// recipe-enabled actuator stages in index order; Moore outputs from state.
module cafeteira_sequenciador
    import cafeteira_sequenciador_pkg::*;
#(
    parameter int NUM_ETAPAS     = 3,
    parameter int TIMEOUT_SENSOR = 50000,
    parameter int TIMEOUT_ETAPA  = 1000000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    cafeteira_sequenciador_if.slave bus
);
    localparam int TW = $clog2(max_int(TIMEOUT_SENSOR, TIMEOUT_ETAPA) + 1);
    localparam int RW = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [RW-1:0] TRY_UM   = RW'(1);
    localparam logic [3:0]    IDX_FIM  = 4'(NUM_ETAPAS);

    estado_t               state_q;
    erro_t                 erro_q;
    logic [3:0]            idx_q;
    logic [RW-1:0]         tries_q;
    logic [NUM_ETAPAS-1:0] mask_q;

    logic          timer_fim, timer_limpa, timer_habilita, cancelavel, ultima_tentativa;
    logic [TW-1:0] timer_limite;
    logic [15:0]   mascara_ext, fim_ext;

    // idx reaches NUM_ETAPAS, so index through zero-extended copies.
    assign mascara_ext      = 16'(mask_q);
    assign fim_ext          = 16'(bus.fim_etapa);
    assign cancelavel       = (state_q >= ST_PREPARA) && (state_q <= ST_EXEC_ETAPA);
    assign ultima_tentativa = (int'(tries_q) + 1) == MAX_TENTATIVAS;

    assign timer_limpa    = (state_q == ST_PREPARA) || (state_q == ST_MEDE_AGUA) ||
                            (state_q == ST_MEDE_XICARA) || (state_q == ST_PROX_ETAPA);
    assign timer_habilita = (state_q == ST_ESPERA_AGUA) || (state_q == ST_ESPERA_XICARA) ||
                            (state_q == ST_EXEC_ETAPA);
    assign timer_limite   = (state_q == ST_EXEC_ETAPA) ? TW'(TIMEOUT_ETAPA) : TW'(TIMEOUT_SENSOR);

    cafeteira_sequenciador_temporizador #(.W(TW)) u_temporizador (
        .clock      (clock),
        .reset      (reset),
        .limpa_i    (timer_limpa),
        .habilita_i (timer_habilita),
        .limite_i   (timer_limite),
        .fim_o      (timer_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INICIAL;
            erro_q  <= ERR_NENHUM;
            idx_q   <= '0;
            tries_q <= '0;
            mask_q  <= '0;
        end else if (bus.cancelar && cancelavel) begin
            state_q <= ST_ERRO;
            erro_q  <= ERR_CANCELADO;
        end else begin
            case (state_q)
                ST_INICIAL: if (bus.preparar) state_q <= ST_PREPARA;
                ST_PREPARA: begin
                    idx_q   <= '0;
                    tries_q <= '0;
                    erro_q  <= ERR_NENHUM;
                    state_q <= ST_ESPERA_MODO;
                end
                ST_ESPERA_MODO: if (bus.pronto_serial) begin
                    mask_q <= bus.mascara_etapas;
                    if (bus.mascara_etapas == '0) begin
                        state_q <= ST_ERRO;
                        erro_q  <= ERR_RECEITA_VAZIA;
                    end else begin
                        state_q <= ST_MEDE_AGUA;
                    end
                end
                ST_MEDE_AGUA: state_q <= ST_ESPERA_AGUA;
                ST_ESPERA_AGUA: begin
                    if (bus.pronto_sensor_agua) begin
                        if (bus.suficiente) begin
                            state_q <= ST_MEDE_XICARA;
                            tries_q <= '0;
                        end else begin
                            state_q <= ST_ERRO;
                            erro_q  <= ERR_SEM_AGUA;
                        end
                    end else if (timer_fim) begin
                        tries_q <= tries_q + TRY_UM;
                        if (ultima_tentativa) begin
                            state_q <= ST_ERRO;
                            erro_q  <= ERR_TIMEOUT_AGUA;
                        end else begin
                            state_q <= ST_MEDE_AGUA;
                        end
                    end
                end
                ST_MEDE_XICARA: state_q <= ST_ESPERA_XICARA;
                ST_ESPERA_XICARA: begin
                    if (bus.pronto_sensor_xicara) begin
                        if (bus.tem_xicara) begin
                            state_q <= ST_PROX_ETAPA;
                            tries_q <= '0;
                        end else begin
                            state_q <= ST_ERRO;
                            erro_q  <= ERR_SEM_XICARA;
                        end
                    end else if (timer_fim) begin
                        tries_q <= tries_q + TRY_UM;
                        if (ultima_tentativa) begin
                            state_q <= ST_ERRO;
                            erro_q  <= ERR_TIMEOUT_XICARA;
                        end else begin
                            state_q <= ST_MEDE_XICARA;
                        end
                    end
                end
                ST_PROX_ETAPA: begin
                    if (idx_q == IDX_FIM) begin
                        state_q <= ST_FIM;
                    end else if (mascara_ext[idx_q]) begin
                        state_q <= ST_EXEC_ETAPA;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_EXEC_ETAPA: begin
                    if (fim_ext[idx_q]) begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= ST_PROX_ETAPA;
                    end else if (timer_fim) begin
                        state_q <= ST_ERRO;
                        erro_q  <= ERR_TIMEOUT_ETAPA;
                    end
                end
                ST_ERRO: state_q <= ST_INICIAL;
                ST_FIM:  state_q <= ST_INICIAL;
                default: state_q <= ST_INICIAL;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_ETAPAS; gi++) begin : g_liga
        assign bus.liga_etapa[gi] = (state_q == ST_EXEC_ETAPA) && (idx_q == 4'(gi));
    end

    assign bus.zera_sensores   = (state_q == ST_PREPARA);
    assign bus.medir_agua      = (state_q == ST_MEDE_AGUA);
    assign bus.verifica_xicara = (state_q == ST_MEDE_XICARA);
    assign bus.ocupado         = (state_q != ST_INICIAL);
    assign bus.concluido       = (state_q == ST_FIM);
    assign bus.erro            = (state_q == ST_ERRO);
    assign bus.erro_codigo     = erro_q;
    assign bus.etapa_atual     = idx_q[2:0];
    assign bus.db_estado       = state_q;

endmodule

// File: tb/tb_cafeteira_sequenciador.sv
// Self-checking bench: a reactive sensor/actuator environment driven by
// per-transaction random parameters, checked against an arithmetic timeline model.
module tb_cafeteira_sequenciador;
    localparam int NE = 3;
    localparam int TS = 8;
    localparam int TE = 16;
    localparam int MT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cafeteira_sequenciador_if #(.NUM_ETAPAS(NE)) bus ();

    cafeteira_sequenciador #(
        .NUM_ETAPAS(NE), .TIMEOUT_SENSOR(TS), .TIMEOUT_ETAPA(TE), .MAX_TENTATIVAS(MT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int prev_code = 0;

    // transaction parameters
    int t_mask, t_sw, t_a_agua, t_d_agua, t_a_xic, t_d_xic, t_cancel_stage, t_cancel_n, t_rst_n;
    bit t_suf, t_tem;
    int t_dur [NE];

    // model results
    int exp_code, exp_busy, exp_medir, exp_verif;
    int exp_liga [NE];

    task automatic check_val(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic clear_inputs();
        bus.preparar = 0; bus.cancelar = 0; bus.pronto_serial = 0; bus.mascara_etapas = '0;
        bus.pronto_sensor_agua = 0; bus.suficiente = 0; bus.pronto_sensor_xicara = 0;
        bus.tem_xicara = 0; bus.fim_etapa = '0;
    endtask

    task automatic set_base();
        t_mask = 7; t_sw = 0; t_a_agua = 0; t_d_agua = 0; t_suf = 1;
        t_a_xic = 0; t_d_xic = 0; t_tem = 1; t_cancel_stage = -1; t_cancel_n = 1; t_rst_n = 0;
        for (int i = 0; i < NE; i++) t_dur[i] = 5;
    endtask

    task automatic gen_random();
        t_mask   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
        t_sw     = int'($urandom_range(0, 3));
        t_a_agua = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MT)) : 0;
        t_d_agua = int'($urandom_range(0, TS - 1));
        t_suf    = ($urandom_range(0, 7) != 0);
        t_a_xic  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MT)) : 0;
        t_d_xic  = int'($urandom_range(0, TS - 1));
        t_tem    = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < NE; i++)
            t_dur[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TE, TE + 3))
                                                    : int'($urandom_range(1, TE - 1));
        t_cancel_stage = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NE - 1)) : -1;
        t_cancel_n     = int'($urandom_range(1, TE));
        t_rst_n        = 0;
    endtask

    // Timeline of one brew, in cycles per phase: PREPARA 1, ESPERA_MODO sw+1,
    // each ignored sensor attempt 1+TS, answered attempt 1+(d+1), one PROX_ETAPA
    // cycle per index visited, each stage its run length, final ERRO/FIM 1.
    task automatic modelo();
        int lim;
        exp_code = 0; exp_busy = 2 + t_sw; exp_medir = 0; exp_verif = 0;
        for (int i = 0; i < NE; i++) exp_liga[i] = 0;
        if (t_mask == 0) begin
            exp_code = 7;
        end else begin
            if (t_a_agua >= MT) begin
                exp_medir = MT; exp_busy += MT * (1 + TS); exp_code = 3;
            end else begin
                exp_medir = t_a_agua + 1; exp_busy += t_a_agua * (1 + TS) + t_d_agua + 2;
                if (!t_suf) exp_code = 1;
            end
            if (exp_code == 0) begin
                if (t_a_xic >= MT) begin
                    exp_verif = MT; exp_busy += MT * (1 + TS); exp_code = 4;
                end else begin
                    exp_verif = t_a_xic + 1; exp_busy += t_a_xic * (1 + TS) + t_d_xic + 2;
                    if (!t_tem) exp_code = 2;
                end
            end
            if (exp_code == 0) begin
                for (int i = 0; i < NE && exp_code == 0; i++) begin
                    exp_busy += 1;
                    if (((t_mask >> i) & 1) != 0) begin
                        lim = (t_dur[i] < TE) ? t_dur[i] : TE;
                        if (t_cancel_stage == i && t_cancel_n <= lim) begin
                            exp_liga[i] = t_cancel_n; exp_code = 6;
                        end else if (t_dur[i] <= TE) begin
                            exp_liga[i] = t_dur[i];
                        end else begin
                            exp_liga[i] = TE; exp_code = 5;
                        end
                        exp_busy += exp_liga[i];
                    end
                end
                if (exp_code == 0) exp_busy += 1;
            end
        end
        exp_busy += 1;
    endtask

    task automatic run_txn(input int id);
        int busy, medir, verif, zera, erro_p, conc_p, cyc, stage, last_medir;
        int since_zera, since_medir, since_verif;
        int liga_cnt [NE];
        bit latched, done, rst_fire, rst_done;
        logic [NE-1:0] fim;
        busy = 0; medir = 0; verif = 0; zera = 0; erro_p = 0; conc_p = 0; last_medir = -1;
        since_zera = -1; since_medir = -1; since_verif = -1;
        latched = 0; done = 0; rst_fire = 0; rst_done = 0;
        for (int i = 0; i < NE; i++) liga_cnt[i] = 0;
        modelo();

        // idle: cancelar must be ignored and the previous code must be held
        @(negedge clock);
        clear_inputs();
        bus.cancelar = ($urandom_range(0, 1) == 1);
        @(negedge clock);
        check_val("idle_ocupado", int'(bus.ocupado), 0);
        check_val("codigo_retido", int'(bus.erro_codigo), prev_code);
        clear_inputs();
        bus.preparar = 1;

        for (cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clock);
            if (rst_fire) begin
                check_val("rst_estado", int'(bus.db_estado), 0);
                check_val("rst_liga", int'(bus.liga_etapa), 0);
                check_val("rst_saidas", int'({bus.zera_sensores, bus.medir_agua, bus.verifica_xicara,
                                              bus.ocupado, bus.concluido, bus.erro}), 0);
                check_val("rst_codigo", int'(bus.erro_codigo), 0);
                reset = 0; clear_inputs(); done = 1; rst_done = 1;
            end else if (!bus.ocupado) begin
                clear_inputs(); done = 1;
            end else begin
                busy++;
                clear_inputs();
                bus.preparar       = ($urandom_range(0, 3) == 0);
                bus.mascara_etapas = NE'($urandom);
                bus.suficiente     = ($urandom_range(0, 1) == 1);
                bus.tem_xicara     = ($urandom_range(0, 1) == 1);
                fim = NE'($urandom);

                if (bus.zera_sensores) begin zera++; since_zera = 0; end
                else if (since_zera >= 0) since_zera++;
                if (!latched && since_zera == t_sw + 1) begin
                    bus.pronto_serial = 1; bus.mascara_etapas = NE'(t_mask); latched = 1;
                end else if (latched) begin
                    bus.pronto_serial = ($urandom_range(0, 1) == 1);
                end

                if (bus.medir_agua) begin
                    medir++;
                    if (last_medir >= 0) check_val("medir_periodo", cyc - last_medir, 1 + TS);
                    last_medir = cyc; since_medir = 0;
                end else if (since_medir >= 0) since_medir++;
                if (medir > t_a_agua && since_medir == t_d_agua + 1) begin
                    bus.pronto_sensor_agua = 1; bus.suficiente = t_suf;
                end

                if (bus.verifica_xicara) begin verif++; since_verif = 0; end
                else if (since_verif >= 0) since_verif++;
                if (verif > t_a_xic && since_verif == t_d_xic + 1) begin
                    bus.pronto_sensor_xicara = 1; bus.tem_xicara = t_tem;
                end

                if (bus.liga_etapa != '0) begin
                    stage = 0;
                    for (int i = 0; i < NE; i++) if (bus.liga_etapa[i]) stage = i;
                    check_val("liga_onehot", $countones(bus.liga_etapa), 1);
                    check_val("etapa_atual", int'(bus.etapa_atual), stage);
                    liga_cnt[stage]++;
                    fim[stage] = (liga_cnt[stage] == t_dur[stage]);
                    if (stage == t_cancel_stage && liga_cnt[stage] == t_cancel_n) bus.cancelar = 1;
                    if (t_rst_n > 0 && stage == 0 && liga_cnt[0] == t_rst_n) begin
                        reset = 1; rst_fire = 1;
                    end
                end
                bus.fim_etapa = fim;
                if (bus.erro) erro_p++;
                if (bus.concluido) conc_p++;
            end
        end

        if (!done) begin
            check_val("orcamento_ciclos", 0, 1);
            reset = 1; clear_inputs();
            @(negedge clock);
            reset = 0;
            prev_code = 0;
        end else if (rst_done) begin
            prev_code = 0;
            $display("txn %0d reset mid-stage: checked outputs cleared", id);
        end else begin
            check_val("ocupado_ciclos", busy, exp_busy);
            check_val("zera_pulsos", zera, 1);
            check_val("medir_pulsos", medir, exp_medir);
            check_val("verifica_pulsos", verif, exp_verif);
            for (int i = 0; i < NE; i++) check_val($sformatf("liga_ciclos[%0d]", i), liga_cnt[i], exp_liga[i]);
            check_val("erro_pulsos", erro_p, (exp_code != 0) ? 1 : 0);
            check_val("concluido_pulsos", conc_p, (exp_code == 0) ? 1 : 0);
            check_val("erro_codigo", int'(bus.erro_codigo), exp_code);
            check_val("estado_final", int'(bus.db_estado), 0);
            prev_code = exp_code;
            $display("txn %0d mask=%0d code=%0d/%0d busy=%0d/%0d", id, t_mask,
                     int'(bus.erro_codigo), exp_code, busy, exp_busy);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (3) @(negedge clock);
        check_val("reset_estado", int'(bus.db_estado), 0);
        check_val("reset_saidas", int'({bus.zera_sensores, bus.medir_agua, bus.verifica_xicara,
                                        bus.ocupado, bus.concluido, bus.erro}), 0);
        check_val("reset_liga", int'(bus.liga_etapa), 0);
        check_val("reset_codigo", int'(bus.erro_codigo), 0);
        reset = 0;

        set_base(); run_txn(0);                                         // all stages, 5 cycles each
        set_base(); t_mask = 5; run_txn(1);                             // stage 1 skipped
        set_base(); t_a_agua = MT; run_txn(2);                          // water timeout
        set_base(); t_tem = 0; run_txn(3);                              // no cup
        set_base(); t_mask = 1; t_dur[0] = TE + 5; run_txn(4);          // stage timeout
        set_base(); t_cancel_stage = 1; t_cancel_n = 3; t_dur[1] = 6; run_txn(5);
        set_base(); t_dur[0] = TE; t_dur[2] = TE; run_txn(6);           // fim on the timeout cycle
        set_base(); t_dur[0] = 10; t_rst_n = 4; run_txn(7);             // reset mid-stage
        set_base(); t_mask = 0; run_txn(8);                             // empty recipe
        set_base(); t_a_agua = 1; t_d_agua = TS - 1; t_a_xic = 1; t_d_xic = TS - 1; run_txn(9);
        set_base(); t_suf = 0; t_d_agua = 3; run_txn(10);               // no water
        set_base(); t_a_xic = MT; run_txn(11);                          // cup timeout

        for (int n = 0; n < 40; n++) begin
            gen_random();
            run_txn(100 + n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
